// File: rtl/servo_pwm_array.sv
// Multi-channel servo PWM generator: one shared frame counter and per-channel
// clamped targets. Active widths slew toward their targets only at the frame wrap.
module servo_pwm_array #(
  parameter int NCH         = 4,
  parameter int PW          = 21,
  parameter int FRAME_TICKS = 2000000,
  parameter int MIN_PULSE   = 100000,
  parameter int MAX_PULSE   = 200000,
  parameter int CENTER      = 150000,
  parameter int STEP        = 5000
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           wr_en,
  input  logic [3:0]     wr_ch,
  input  logic [PW-1:0]  wr_pulse,
  output logic           wr_err,
  output logic [NCH-1:0] pwm,
  output logic           frame_start,
  output logic           busy
);

  localparam logic [PW-1:0] LAST  = PW'(FRAME_TICKS - 1);
  localparam logic [PW-1:0] MINP  = PW'(MIN_PULSE);
  localparam logic [PW-1:0] MAXP  = PW'(MAX_PULSE);
  localparam logic [PW-1:0] CEN   = PW'(CENTER);
  localparam logic [PW:0]   STEPW = (PW+1)'(STEP);

  logic [PW-1:0]  cnt, cnt_nxt;
  logic [PW-1:0]  tgt [NCH];
  logic [PW-1:0]  cur [NCH];
  logic [PW-1:0]  tgt_nxt [NCH];
  logic [PW-1:0]  cur_nxt [NCH];
  logic [PW:0]    up [NCH];
  logic           wrap, wr_bad;
  logic [PW-1:0]  wr_clamped;
  logic [NCH-1:0] pwm_nxt, diff;

  always_comb begin
    wrap    = (cnt == LAST);
    cnt_nxt = wrap ? '0 : cnt + PW'(1);
    wr_bad  = wr_en && ({1'b0, wr_ch} >= 5'(NCH));
    if (wr_pulse < MINP)      wr_clamped = MINP;
    else if (wr_pulse > MAXP) wr_clamped = MAXP;
    else                      wr_clamped = wr_pulse;

    for (int unsigned i = 0; i < NCH; i++) begin
      up[i]      = {1'b0, cur[i]} + STEPW;
      cur_nxt[i] = cur[i];
      if (wrap) begin
        if (STEP == 0)
          cur_nxt[i] = tgt[i];
        else if (cur[i] < tgt[i])
          cur_nxt[i] = (up[i] >= {1'b0, tgt[i]}) ? tgt[i] : up[i][PW-1:0];
        else if (cur[i] > tgt[i])
          cur_nxt[i] = ({1'b0, cur[i]} > ({1'b0, tgt[i]} + STEPW)) ?
                       cur[i] - STEPW[PW-1:0] : tgt[i];
      end
      tgt_nxt[i] = (wr_en && ({1'b0, wr_ch} == 5'(i))) ? wr_clamped : tgt[i];
      // Compare against next-cycle counter/width so the pulse rises with frame_start.
      pwm_nxt[i] = (cnt_nxt < cur_nxt[i]);
      diff[i]    = (cur_nxt[i] != tgt_nxt[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      frame_start <= 1'b0;
      wr_err      <= 1'b0;
      busy        <= 1'b0;
      pwm         <= '0;
      for (int unsigned i = 0; i < NCH; i++) begin
        tgt[i] <= CEN;
        cur[i] <= CEN;
      end
    end else begin
      cnt         <= cnt_nxt;
      frame_start <= wrap;
      wr_err      <= wr_bad;
      busy        <= |diff;
      pwm         <= pwm_nxt;
      for (int unsigned i = 0; i < NCH; i++) begin
        tgt[i] <= tgt_nxt[i];
        cur[i] <= cur_nxt[i];
      end
    end
  end

endmodule

// File: tb/tb_servo_pwm_array.sv
// Bench for servo_pwm_array: two instances (STEP=2 and STEP=0) share stimulus and
// are checked frame by frame against a per-channel target/width model.
module tb_servo_pwm_array;

  localparam int NCH = 4;
  localparam int PW  = 8;
  localparam int FT  = 100;
  localparam int MINP = 10;
  localparam int MAXP = 20;
  localparam int CEN  = 15;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           wr_en = 1'b0;
  logic [3:0]     wr_ch = '0;
  logic [PW-1:0]  wr_pulse = '0;
  logic           wr_err_a, wr_err_b, fs_a, fs_b, busy_a, busy_b;
  logic [NCH-1:0] pwm_a, pwm_b;

  int n_tests = 0;
  int n_fail  = 0;

  int m_tgt [2][NCH];
  int m_cur [2][NCH];
  int steps [2] = '{2, 0};
  logic m_werr = 1'b0;

  always #5 clk = ~clk;

  servo_pwm_array #(.NCH(NCH), .PW(PW), .FRAME_TICKS(FT), .MIN_PULSE(MINP),
                    .MAX_PULSE(MAXP), .CENTER(CEN), .STEP(2)) dut_a (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_ch(wr_ch), .wr_pulse(wr_pulse),
    .wr_err(wr_err_a), .pwm(pwm_a), .frame_start(fs_a), .busy(busy_a));

  servo_pwm_array #(.NCH(NCH), .PW(PW), .FRAME_TICKS(FT), .MIN_PULSE(MINP),
                    .MAX_PULSE(MAXP), .CENTER(CEN), .STEP(0)) dut_b (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_ch(wr_ch), .wr_pulse(wr_pulse),
    .wr_err(wr_err_b), .pwm(pwm_b), .frame_start(fs_b), .busy(busy_b));

  function automatic int clampv(input int v);
    if (v < MINP) return MINP;
    if (v > MAXP) return MAXP;
    return v;
  endfunction

  function automatic int slewv(input int c, input int t, input int s);
    if (s == 0) return t;
    if (c < t) return (c + s < t) ? c + s : t;
    if (c > t) return (c - s > t) ? c - s : t;
    return c;
  endfunction

  function automatic logic exp_busy(input int k);
    for (int ch = 0; ch < NCH; ch++)
      if (m_cur[k][ch] != m_tgt[k][ch]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++)
      for (int ch = 0; ch < NCH; ch++) begin
        m_tgt[k][ch] = CEN;
        m_cur[k][ch] = CEN;
      end
    m_werr = 1'b0;
  endtask

  task automatic step_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Runs one full frame starting at the cycle where the counter shows 0,
  // with up to two writes at frame-relative cycles wa0/wa1 (-1 = none).
  task automatic measure(input string tag, input int wa0, input int wc0, input int wv0,
                         input int wa1, input int wc1, input int wv1);
    int hi [2][NCH];
    int exp_w [2][NCH];
    int shape_err, busy_err, fs_err, werr_err, wa, wc, wv;
    logic [NCH-1:0] p;
    logic fs, b, we;
    shape_err = 0; busy_err = 0; fs_err = 0; werr_err = 0;
    for (int k = 0; k < 2; k++)
      for (int ch = 0; ch < NCH; ch++) begin
        hi[k][ch] = 0;
        exp_w[k][ch] = m_cur[k][ch];
      end
    for (int c = 0; c < FT; c++) begin
      for (int k = 0; k < 2; k++) begin
        p  = (k == 0) ? pwm_a : pwm_b;
        fs = (k == 0) ? fs_a : fs_b;
        b  = (k == 0) ? busy_a : busy_b;
        we = (k == 0) ? wr_err_a : wr_err_b;
        if (fs !== (c == 0)) fs_err++;
        if (b !== exp_busy(k)) busy_err++;
        if (we !== m_werr) werr_err++;
        for (int ch = 0; ch < NCH; ch++) begin
          if (p[ch] === 1'b1) hi[k][ch]++;
          if (p[ch] !== (c < exp_w[k][ch])) shape_err++;
        end
      end
      wa = -1; wc = 0; wv = 0;
      if (c == wa0) begin wa = c; wc = wc0; wv = wv0; end
      else if (c == wa1) begin wa = c; wc = wc1; wv = wv1; end
      if (wa >= 0) begin
        wr_en = 1'b1; wr_ch = 4'(wc); wr_pulse = PW'(wv);
      end
      @(posedge clk);
      #1;
      wr_en = 1'b0;
      if (c == FT - 1)
        for (int k = 0; k < 2; k++)
          for (int ch = 0; ch < NCH; ch++)
            m_cur[k][ch] = slewv(m_cur[k][ch], m_tgt[k][ch], steps[k]);
      m_werr = 1'b0;
      if (wa >= 0) begin
        if (wc < NCH)
          for (int k = 0; k < 2; k++) m_tgt[k][wc] = clampv(wv);
        else
          m_werr = 1'b1;
      end
    end
    for (int k = 0; k < 2; k++)
      for (int ch = 0; ch < NCH; ch++) begin
        n_tests++;
        if (hi[k][ch] !== exp_w[k][ch]) begin
          n_fail++;
          $display("FAIL %s width inst%0d ch%0d: got %0d, expected %0d",
                   tag, k, ch, hi[k][ch], exp_w[k][ch]);
        end
      end
    n_tests++;
    if (shape_err !== 0) begin
      n_fail++; $display("FAIL %s pwm_shape: %0d bad cycles, expected 0", tag, shape_err);
    end
    n_tests++;
    if (fs_err !== 0) begin
      n_fail++; $display("FAIL %s frame_start: %0d bad cycles, expected 0", tag, fs_err);
    end
    n_tests++;
    if (busy_err !== 0) begin
      n_fail++; $display("FAIL %s busy: %0d bad cycles, expected 0", tag, busy_err);
    end
    n_tests++;
    if (werr_err !== 0) begin
      n_fail++; $display("FAIL %s wr_err: %0d bad cycles, expected 0", tag, werr_err);
    end
  endtask

  task automatic check_quiet(input string tag);
    n_tests++;
    if ({pwm_a, pwm_b, fs_a, fs_b, busy_a, busy_b, wr_err_a, wr_err_b} !== '0) begin
      n_fail++;
      $display("FAIL %s outputs: got pwm_a=%b pwm_b=%b fs=%b%b busy=%b%b wr_err=%b%b, expected all 0",
               tag, pwm_a, pwm_b, fs_a, fs_b, busy_a, busy_b, wr_err_a, wr_err_b);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; wr_en = 1'b0;
    step_cycles(2);
    check_quiet("reset");
    rst = 1'b0;
    model_reset();
    step_cycles(FT);
  endtask

  task automatic test_idle();
    for (int f = 0; f < 3; f++) measure("idle", -1, 0, 0, -1, 0, 0);
  endtask

  task automatic test_ramp();
    measure("ramp_wr", 30, 1, 20, -1, 0, 0);
    for (int f = 0; f < 4; f++) measure("ramp", -1, 0, 0, -1, 0, 0);
  endtask

  task automatic test_clamp();
    measure("clamp_wr", 20, 2, 3, 21, 3, 200);
    for (int f = 0; f < 3; f++) measure("clamp", -1, 0, 0, -1, 0, 0);
  endtask

  task automatic test_out_of_range();
    measure("oor_wr", 50, 5, 12, 70, 15, 18);
    measure("oor", -1, 0, 0, -1, 0, 0);
  endtask

  task automatic test_wrap_write();
    measure("wrapwr_wr", FT - 1, 0, 11, -1, 0, 0);
    for (int f = 0; f < 3; f++) measure("wrapwr", -1, 0, 0, -1, 0, 0);
  endtask

  task automatic test_back_to_back();
    measure("b2b_wr", 60, 3, 12, 61, 3, 18);
    for (int f = 0; f < 3; f++) measure("b2b", -1, 0, 0, -1, 0, 0);
  endtask

  task automatic test_random();
    int wa0, wc0, wv0, wa1, wc1, wv1;
    for (int f = 0; f < 12; f++) begin
      wa0 = $urandom_range(0, FT - 1);
      wc0 = $urandom_range(0, 6);
      wv0 = $urandom_range(0, 255);
      wa1 = ($urandom_range(0, 1) == 1) ? $urandom_range(0, FT - 1) : -1;
      wc1 = $urandom_range(0, 6);
      wv1 = $urandom_range(0, 255);
      measure("random", wa0, wc0, wv0, wa1, wc1, wv1);
    end
    for (int f = 0; f < 6; f++) measure("settle", -1, 0, 0, -1, 0, 0);
  endtask

  task automatic test_reset_midramp();
    measure("midrst_wr", 10, 1, 10, 11, 2, 20);
    step_cycles(5);
    n_tests++;
    if (pwm_a !== 4'b1111) begin
      n_fail++; $display("FAIL midrst_pre pwm_a: got %b, expected 1111", pwm_a);
    end
    rst = 1'b1;
    step_cycles(1);
    rst = 1'b0;
    check_quiet("midrst");
    model_reset();
    step_cycles(FT);
    for (int f = 0; f < 2; f++) measure("post_rst", -1, 0, 0, -1, 0, 0);
  endtask

  initial begin
    test_reset();
    test_idle();
    test_ramp();
    test_clamp();
    test_out_of_range();
    test_wrap_write();
    test_back_to_back();
    test_random();
    test_reset_midramp();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
